// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded controls, operands and register indices.
// It handles stall and flush, and inserts its own bubble when it detects a load-use hazard.
module id_ex_stage_reg #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 5
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [2:0]            id_funct3,
    input  logic [ALU_OP_W-1:0]   id_alu_opcode,
    input  logic                  id_mux1_select,
    input  logic                  id_mux2_select,
    input  logic                  id_mux3_select,
    input  logic                  id_regwrite_enable,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  id_jal_select,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  load_use_hazard,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [2:0]            ex_funct3,
    output logic [ALU_OP_W-1:0]   ex_alu_opcode,
    output logic                  ex_mux1_select,
    output logic                  ex_mux2_select,
    output logic                  ex_mux3_select,
    output logic                  ex_regwrite_enable,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_jal_select
);

    logic id_live;
    logic bubble;

    // Case equality maps X/Z on a decoded control to 0 so it never reaches EX.
    function automatic logic sanitize(input logic b);
        return (b === 1'b1);
    endfunction

    assign id_live = sanitize(id_valid);

    // rs1 and rs2 are compared even when the instruction does not read them.
    assign load_use_hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                             ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    assign bubble = flush | (~stall & load_use_hazard);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ex_valid           <= 1'b0;
            ex_pc              <= '0;
            ex_rs1_data        <= '0;
            ex_rs2_data        <= '0;
            ex_imm             <= '0;
            ex_rs1             <= '0;
            ex_rs2             <= '0;
            ex_rd              <= '0;
            ex_funct3          <= '0;
            ex_alu_opcode      <= '0;
            ex_mux1_select     <= 1'b0;
            ex_mux2_select     <= 1'b0;
            ex_mux3_select     <= 1'b0;
            ex_regwrite_enable <= 1'b0;
            ex_mem_read        <= 1'b0;
            ex_mem_write       <= 1'b0;
            ex_branch          <= 1'b0;
            ex_jump            <= 1'b0;
            ex_jal_select      <= 1'b0;
        end else if (bubble) begin
            ex_valid           <= 1'b0;
            ex_pc              <= '0;
            ex_rs1_data        <= '0;
            ex_rs2_data        <= '0;
            ex_imm             <= '0;
            ex_rs1             <= '0;
            ex_rs2             <= '0;
            ex_rd              <= '0;
            ex_funct3          <= '0;
            ex_alu_opcode      <= '0;
            ex_mux1_select     <= 1'b0;
            ex_mux2_select     <= 1'b0;
            ex_mux3_select     <= 1'b0;
            ex_regwrite_enable <= 1'b0;
            ex_mem_read        <= 1'b0;
            ex_mem_write       <= 1'b0;
            ex_branch          <= 1'b0;
            ex_jump            <= 1'b0;
            ex_jal_select      <= 1'b0;
        end else if (!stall) begin
            ex_valid           <= id_live;
            ex_pc              <= id_pc;
            ex_rs1_data        <= id_rs1_data;
            ex_rs2_data        <= id_rs2_data;
            ex_imm             <= id_imm;
            ex_rs1             <= id_rs1;
            ex_rs2             <= id_rs2;
            ex_rd              <= id_rd;
            ex_funct3          <= id_funct3;
            ex_alu_opcode      <= id_alu_opcode;
            ex_mux1_select     <= id_live & sanitize(id_mux1_select);
            ex_mux2_select     <= id_live & sanitize(id_mux2_select);
            ex_mux3_select     <= id_live & sanitize(id_mux3_select);
            ex_regwrite_enable <= id_live & sanitize(id_regwrite_enable);
            ex_mem_read        <= id_live & sanitize(id_mem_read);
            ex_mem_write       <= id_live & sanitize(id_mem_write);
            ex_branch          <= id_live & sanitize(id_branch);
            ex_jump            <= id_live & sanitize(id_jump);
            ex_jal_select      <= id_live & sanitize(id_jal_select);
        end
    end

endmodule
